// File: rtl/ram_port_ctrl.sv
// Single-request bridge from a byte-addressed valid/ready port to a synchronous
// word RAM. Partial writes are done as read-modify-write; out-of-range requests get an error response.
module ram_port_ctrl #(
   parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
   parameter logic [31:0] RAM_WORDS = 32'd1048576
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] ram_rIdx,
   input  logic [31:0] ram_rdata,
   output logic [31:0] ram_wIdx,
   output logic [31:0] ram_wdata,
   output logic        ram_wen
);

   localparam int unsigned BYTES = 4;

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t      state, state_d;
   logic [31:0] idx_q, data_q, wdata_q;
   logic [3:0]  wmask_q;
   logic        wen_q, err_q;
   logic        accept, in_range;
   logic [31:0] idx_n, merged;

   assign idx_n    = 32'(req_addr - RAM_BASE) >> 2;
   // Compare before subtracting so addresses below the base never wrap into range.
   assign in_range = (req_addr >= RAM_BASE) && (idx_n < RAM_WORDS);
   assign accept   = req_valid && req_ready;

   // Byte merge of new write data over the word just read from RAM.
   always_comb begin
      merged = ram_rdata;
      for (int i = 0; i < int'(BYTES); i++) begin
         if (wmask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!in_range)                state_d = RESP;
               else if (!req_wen)            state_d = RD;
               else if (req_wmask == 4'hF)   state_d = WR;
               else if (req_wmask == 4'h0)   state_d = RESP;
               else                          state_d = RD;
            end
         end
         RD:      state_d = CAP;
         CAP:     state_d = wen_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transaction registers: loaded on accept, read data captured in CAP.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= 32'h0;
         data_q  <= 32'h0;
         wdata_q <= 32'h0;
         wmask_q <= 4'h0;
         wen_q   <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept) begin
         idx_q   <= idx_n;
         wdata_q <= req_wdata;
         wmask_q <= req_wmask;
         wen_q   <= req_wen;
         err_q   <= !in_range;
         data_q  <= (in_range && req_wen && req_wmask == 4'hF) ? req_wdata : 32'h0;
      end else if (state == CAP) begin
         data_q  <= wen_q ? merged : ram_rdata;
      end
   end

   assign req_ready  = (state == IDLE) && !reset;
   assign resp_valid = (state == RESP) && !reset;
   assign resp_rdata = data_q;
   assign resp_err   = err_q;
   assign ram_rIdx   = idx_q;
   assign ram_wIdx   = idx_q;
   assign ram_wdata  = data_q;
   assign ram_wen    = (state == WR) && !reset;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a small synchronous RAM model (16 words, index aliased).
module tb_ram_port_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata;
   logic        ram_wen;

   logic [31:0] mem [0:15];
   logic [31:0] ram_q;
   logic        pl_en;
   logic [3:0]  pl_idx;
   logic [31:0] pl_data;
   int          wen_cnt;
   logic [31:0] last_widx;
   int          total, bad;

   ram_port_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata),
      .ram_wIdx(ram_wIdx), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
   );

   always #5 clk = ~clk;

   assign ram_rdata = ram_q;

   always @(posedge clk) begin
      if (pl_en)        mem[pl_idx] <= pl_data;
      else if (ram_wen) mem[ram_wIdx[3:0]] <= ram_wdata;
      ram_q <= mem[ram_rIdx[3:0]];
      if (ram_wen) begin
         wen_cnt   <= wen_cnt + 1;
         last_widx <= ram_wIdx;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] data);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      tick();
      pl_en = 1'b0;
   endtask

   // One transaction; junk request kept on the port while busy must be ignored.
   task automatic xact(input string tag, input logic [31:0] addr, input logic w,
                       input logic [31:0] wd, input logic [3:0] wm, input int hold,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      int n;
      int lat;
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = addr; req_wen = w; req_wdata = wd; req_wmask = wm;
      tick();
      req_addr = 32'h8000_0004; req_wen = 1'b1; req_wdata = 32'hBAD0BAD0; req_wmask = 4'hF;
      lat = 1;
      while (!resp_valid && lat < 20) begin tick(); lat++; end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
         check({tag, "_hold_rdata"}, resp_rdata, exp_rd);
         check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
         tick();
      end
      check({tag, "_rdata"}, resp_rdata, exp_rd);
      check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check({tag, "_exit_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_exit_idle"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int w0;
      total = 0; bad = 0; wen_cnt = 0; last_widx = 32'h0;
      reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wen = 1'b0;
      req_wdata = 32'h0; req_wmask = 4'h0; resp_ready = 1'b0;
      pl_en = 1'b0; pl_idx = 4'h0; pl_data = 32'h0;

      for (int i = 0; i < 16; i++) preload(4'(i), 32'h0);
      preload(4'd3, 32'hAABBCCDD);
      preload(4'd5, 32'hDEADBEEF);
      preload(4'd7, 32'h01020304);
      preload(4'd15, 32'hCAFEF00D);

      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_ram_wen", 32'(ram_wen), 32'd0);
      check("rst_ram_ridx", ram_rIdx, 32'h0);
      check("rst_ram_widx", ram_wIdx, 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);

      xact("rd5", 32'h8000_0014, 1'b0, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 3);
      check("rd5_no_wen", 32'(wen_cnt), 32'd0);

      xact("wr2", 32'h8000_0008, 1'b1, 32'h12345678, 4'hF, 0, 32'h12345678, 1'b0, 2);
      check("wr2_wen_cnt", 32'(wen_cnt), 32'd1);
      check("wr2_widx", last_widx, 32'd2);
      check("wr2_mem", mem[2], 32'h12345678);
      xact("rd2", 32'h8000_0008, 1'b0, 32'h0, 4'h0, 0, 32'h12345678, 1'b0, 3);

      xact("pw3", 32'h8000_000C, 1'b1, 32'h11223344, 4'b0101, 0, 32'hAA22CC44, 1'b0, 4);
      check("pw3_wen_cnt", 32'(wen_cnt), 32'd2);
      check("pw3_mem", mem[3], 32'hAA22CC44);

      xact("err_lo", 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b1, 1);
      xact("err_hi", 32'h8040_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b1, 1);
      xact("err_wr", 32'h8040_0004, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b1, 1);
      check("err_no_wen", 32'(wen_cnt), 32'd2);
      xact("last_word", 32'h803F_FFFC, 1'b0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0, 3);

      xact("mask0", 32'h8000_0014, 1'b1, 32'h99999999, 4'h0, 0, 32'h0, 1'b0, 1);
      check("mask0_no_wen", 32'(wen_cnt), 32'd2);
      check("mask0_mem", mem[5], 32'hDEADBEEF);

      xact("bp", 32'h8000_0014, 1'b0, 32'h0, 4'h0, 5, 32'hDEADBEEF, 1'b0, 3);

      // Reset in the CAP cycle of a partial write.
      w0 = wen_cnt;
      req_valid = 1'b1; req_addr = 32'h8000_001C; req_wen = 1'b1;
      req_wdata = 32'hAAAAAAAA; req_wmask = 4'b0011;
      tick();
      req_valid = 1'b0;
      tick();
      check("mid_ridx", ram_rIdx, 32'd7);
      reset = 1'b1;
      #1;
      check("mid_wen_gated", 32'(ram_wen), 32'd0);
      tick();
      check("mid_rst_valid", 32'(resp_valid), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      check("mid_rst_ridx", ram_rIdx, 32'h0);
      check("mid_rst_wdata", ram_wdata, 32'h0);
      reset = 1'b0;
      #1;
      check("mid_idle", 32'(req_ready), 32'd1);
      tick(); tick();
      check("mid_no_wen", 32'(wen_cnt), 32'(w0));
      check("mid_mem", mem[7], 32'h01020304);
      check("mid_no_resp", 32'(resp_valid), 32'd0);
      xact("rd7", 32'h8000_001C, 1'b0, 32'h0, 4'h0, 0, 32'h01020304, 1'b0, 3);

      // Reset during WR must suppress the write enable combinationally.
      w0 = wen_cnt;
      req_valid = 1'b1; req_addr = 32'h8000_0024; req_wen = 1'b1;
      req_wdata = 32'h55AA55AA; req_wmask = 4'hF;
      tick();
      req_valid = 1'b0;
      check("wr_state_wen", 32'(ram_wen), 32'd1);
      check("wr_state_widx", ram_wIdx, 32'd9);
      reset = 1'b1;
      #1;
      check("wr_wen_gated", 32'(ram_wen), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("wr_rst_no_wen", 32'(wen_cnt), 32'(w0));
      check("wr_rst_mem", mem[9], 32'h0);
      check("wr_rst_idle", 32'(req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 SHALL have parameter RAM_BASE, default 32'h8000_0000, byte address mapped to RAM word index 0.
REQ-002 SHALL have parameter RAM_WORDS, default 32'd1048576, number of 32-bit words backed by the RAM.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  controller accepts request this cycle.
REQ-007 req_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 req_wen  in  1  1 = write, 0 = read.
REQ-009 req_wdata  in  32  write data.
REQ-010 req_wmask  in  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  consumer accepts response.
REQ-013 resp_rdata  out  32  read data, or merged word for writes.
REQ-014 resp_err  out  1  address out of range.
REQ-015 ram_rIdx  out  32  word index to RAM read port.
REQ-016 ram_rdata  in  32  RAM read data; valid the cycle after ram_rIdx is presented.
REQ-017 ram_wIdx  out  32  word index to RAM write port.
REQ-018 ram_wdata  out  32  word to RAM write port.
REQ-019 ram_wen  out  1  RAM write enable; write commits at the rising edge.

Function
REQ-020 SHALL implement FSM states IDLE, RD, CAP, WR, RESP.
REQ-021 SHALL assert req_ready only in IDLE; accept on req_valid && req_ready.
REQ-022 SHALL, on accept, register idx_q = (req_addr - RAM_BASE) >> 2 (32-bit unsigned), plus wen, wdata and wmask.
REQ-023 SHALL flag out-of-range when req_addr < RAM_BASE or idx >= RAM_WORDS; IDLE -> RESP with resp_err = 1 and resp_rdata = 0; no RAM write.
REQ-024 In-range read: IDLE -> RD -> CAP -> RESP; capture ram_rdata into data_q in CAP; resp_valid first asserted 3 cycles after the accept edge.
REQ-025 In-range write with wmask = 4'hF: IDLE -> WR -> RESP; data_q = req_wdata.
REQ-026 In-range write with mask neither 4'hF nor 4'h0: IDLE -> RD -> CAP -> WR -> RESP; in CAP, data_q = per byte (wmask[i] ? wdata byte : ram_rdata byte).
REQ-027 In-range write with wmask = 4'h0: IDLE -> RESP with no RAM write; resp_rdata = 0.
REQ-028 ram_rIdx and ram_wIdx SHALL be driven from idx_q in every state.
REQ-029 ram_wdata SHALL be driven from data_q.
REQ-030 ram_wen SHALL be 1 only in WR, for exactly one cycle per write.
REQ-031 RESP: resp_valid = 1; resp_rdata = data_q; resp_err held stable; all response outputs held until resp_ready.
REQ-032 RESP exits to IDLE on the edge where resp_ready = 1; no new request accepted in that same cycle.
REQ-033 resp_ready already high on the first RESP cycle SHALL give a one-cycle response.
REQ-034 req_* inputs SHALL be ignored outside IDLE; only one transaction outstanding.
REQ-035 Address arithmetic SHALL be unsigned 32-bit with no wrap-around acceptance; addresses below RAM_BASE are errors per REQ-023.

Reset
REQ-036 reset = 1 at an edge SHALL force state to IDLE, idx_q = 0, data_q = 0, and internal err = 0.
REQ-037 Outputs SHALL hold these reset values while reset = 1: req_ready = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, ram_wen = 0, ram_rIdx = 0, ram_wIdx = 0, ram_wdata = 0.
REQ-038 reset during RD, CAP, WR or RESP SHALL abort the transaction with no RAM write and no response.
REQ-039 ram_wen SHALL be gated low combinationally whenever reset = 1.

Verification
REQ-040 Read: preload word 5 = 32'hDEADBEEF; read 32'h8000_0014 -> resp_rdata = DEADBEEF, resp_err = 0, resp_valid 3 cycles after accept.
REQ-041 Full write: write 32'h8000_0008 data 32'h12345678 mask F -> one ram_wen pulse, wIdx = 2; subsequent read returns 12345678.
REQ-042 Partial write: word 3 = 32'hAABBCCDD; write 32'h8000_000C data 32'h11223344 mask 4'b0101 -> RAM word = 32'hAA22CC44, resp_rdata = AA22CC44.
REQ-043 Errors: reads of 32'h7FFF_FFFC and 32'h8040_0000 -> resp_err = 1, resp_rdata = 0, ram_wen never asserted.
REQ-044 Backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable; req_ready = 0 throughout; exit on the first resp_ready edge.
REQ-045 Reset mid-op: assert reset in the CAP cycle of a partial write -> no ram_wen pulse, RAM word unchanged, FSM in IDLE after release.
